// File: rtl/trigger_scheduler.sv
// trigger_scheduler: one periodic trigger generator shared round-robin between
// NREQ requesters; each grant runs a burst of count[i] pulses every period[i] cycles.
module trigger_scheduler #(
    parameter int NREQ = 4,
    parameter int PW   = 8,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*PW-1:0]   period,
    input  logic [NREQ*CW-1:0]   count,
    input  logic                 abort,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 aborted,
    output logic                 trigger,
    output logic                 busy
);

    localparam int unsigned     NR  = NREQ;
    localparam int              IW  = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   cnt_q;
    logic [CW-1:0]   k_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            aborted_q;
    logic            trigger_q;
    logic            busy_q;

    logic            win_vld_d;
    logic [IW-1:0]   win_idx_d;
    logic [PW-1:0]   win_p_d;
    logic [CW-1:0]   win_k_d;
    int unsigned     cand;

    // Round-robin winner: first set req bit searching upward from ptr_q, wrapping.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        win_p_d   = '0;
        win_k_d   = '0;
        cand      = 0;
        for (int unsigned off = 0; off < NR; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= NR) begin
                cand = cand - NR;
            end
            if (!win_vld_d && req[cand[IW-1:0]]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand[IW-1:0];
            end
        end
        for (int unsigned i = 0; i < NR; i++) begin
            if (win_idx_d == IW'(i)) begin
                win_p_d = period[PW*i +: PW];
                win_k_d = count[CW*i +: CW];
            end
        end
    end

    // Sequencer: grant/latch in IDLE, count out pulses in RUN, one-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q    <= '0;
                    aborted_q <= 1'b0;
                    trigger_q <= 1'b0;
                    if (win_vld_d) begin
                        idx_q  <= win_idx_d;
                        gnt_q  <= ONE << win_idx_d;
                        p_q    <= (win_p_d == '0) ? PW'(1) : win_p_d;
                        k_q    <= win_k_d;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (win_k_d != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= ONE << win_idx_d;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        cnt_q     <= '0;
                        trigger_q <= 1'b0;
                        aborted_q <= 1'b1;
                        done_q    <= gnt_q;
                        state_q   <= S_DONE;
                    end else if (cnt_q == p_q - PW'(1)) begin
                        cnt_q     <= '0;
                        k_q       <= k_q - CW'(1);
                        trigger_q <= 1'b1;
                        if (k_q == CW'(1)) begin
                            done_q  <= gnt_q;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q     <= cnt_q + PW'(1);
                        trigger_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= '0;
                    done_q    <= '0;
                    aborted_q <= 1'b0;
                    trigger_q <= 1'b0;
                    busy_q    <= 1'b0;
                    ptr_q     <= (idx_q == IW'(NR - 1)) ? '0 : idx_q + IW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign trigger = trigger_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// tb_trigger_scheduler: directed scenarios plus random traffic, checked every cycle
// against a burst-schedule model (grant cycle, period, count, abort cycle).
module tb_trigger_scheduler;

    localparam int NREQ = 4;
    localparam int PW   = 8;
    localparam int CW   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*PW-1:0]  period;
    logic [NREQ*CW-1:0]  count;
    logic                abort;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                aborted;
    logic                trigger;
    logic                busy;

    always #5 clk = ~clk;

    trigger_scheduler #(.NREQ(NREQ), .PW(PW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .period(period), .count(count),
        .abort(abort), .gnt(gnt), .done(done), .aborted(aborted),
        .trigger(trigger), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Burst-level reference: owner, first RUN cycle, end (DONE) cycle, abort flag.
    bit m_busy  = 1'b0;
    bit m_abt   = 1'b0;
    int m_owner = 0;
    int m_start = 0;
    int m_end   = 0;
    int m_p     = 1;
    int m_ptr   = 0;

    function automatic void model_edge(int n);
        bit found = 1'b0;
        int k;
        if (rst) begin
            m_busy = 1'b0;
            m_abt  = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            for (int o = 0; o < NREQ; o++) begin
                int j = (m_ptr + o) % NREQ;
                if (!found && req[j]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_abt   = 1'b0;
                    m_owner = j;
                    m_p     = (period[PW*j +: PW] == 0) ? 1 : int'(period[PW*j +: PW]);
                    k       = int'(count[CW*j +: CW]);
                    m_start = n + 1;
                    m_end   = (k == 0) ? n + 1 : n + 1 + m_p * k;
                end
            end
        end else if (n == m_end) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NREQ;
        end else if (abort) begin
            m_end = n + 1;
            m_abt = 1'b1;
        end
    endfunction

    task automatic compare(input int c);
        logic [31:0] e_gnt;
        logic        last;
        logic        e_trig;
        e_gnt  = m_busy ? (32'd1 << m_owner) : 32'd0;
        last   = m_busy && (c == m_end);
        e_trig = m_busy && (c > m_start) && (c <= m_end) && (((c - m_start) % m_p) == 0)
                 && !(m_abt && (c == m_end));
        chk("gnt", gnt, e_gnt);
        chk("done", done, last ? e_gnt : 32'd0);
        chk("aborted", aborted, last && m_abt);
        chk("trigger", trigger, e_trig);
        chk("busy", busy, m_busy);
    endtask

    int n_trig;
    int first_trig;
    int done_cyc;
    bit done_abt;
    bit prev_g = 1'b0;
    int g_who[$];
    int g_cyc[$];

    task automatic clear_stats();
        n_trig     = 0;
        first_trig = -1;
        done_cyc   = -1;
        done_abt   = 1'b0;
        g_who.delete();
        g_cyc.delete();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(cyc);
        cyc++;
        #1;
        compare(cyc);
        if (trigger) begin
            n_trig++;
            if (first_trig < 0) first_trig = cyc;
        end
        if (|done) begin
            done_cyc = cyc;
            done_abt = aborted;
        end
        if (|gnt && !prev_g) begin
            g_who.push_back($clog2(gnt));
            g_cyc.push_back(cyc);
        end
        prev_g = |gnt;
    endtask

    task automatic set_cfg(input int i, input int p, input int k);
        period[PW*i +: PW] = PW'(p);
        count[CW*i +: CW]  = CW'(k);
    endtask

    // Runs until the current/next burst is over; requesters drop req on their done.
    task automatic run_burst(input int abort_at, input int chg_at, input int max_cyc);
        bit started = 1'b0;
        int k = 0;
        clear_stats();
        while (k < max_cyc) begin
            step();
            k++;
            if (busy) started = 1'b1;
            abort = (cyc == abort_at);
            req   = req & ~done;
            if (cyc == chg_at) begin
                for (int i = 0; i < NREQ; i++) set_cfg(i, 7, 1);
                req = '0;
            end
            if (started && !busy) break;
        end
        abort = 1'b0;
        chk("burst_end", {30'd0, started, busy}, 32'd2);
    endtask

    initial begin
        int t0;
        rst    = 1'b1;
        req    = '0;
        abort  = 1'b0;
        period = '0;
        count  = '0;
        clear_stats();
        step();
        step();
        rst = 1'b0;

        // single burst: period 3, count 2
        set_cfg(0, 3, 2);
        req = 4'b0001;
        t0  = cyc;
        run_burst(-1, -1, 50);
        chk("sb_first_trig", first_trig - t0, 4);
        chk("sb_ntrig", n_trig, 2);
        chk("sb_done_cyc", done_cyc - t0, 7);

        // round robin from ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_cfg(i, 1, 1);
        req = '1;
        t0  = cyc;
        clear_stats();
        repeat (16) step();
        chk("rr_ngrants_ok", g_who.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < g_who.size()) begin
                chk("rr_owner", g_who[i], i % NREQ);
                chk("rr_grant_cyc", g_cyc[i] - t0, 1 + 3 * i);
            end
        end
        req = '0;
        run_burst(-1, -1, 20);

        // abort in RUN with cnt=4 of the second period
        set_cfg(2, 5, 3);
        req = 4'b0100;
        t0  = cyc;
        run_burst(t0 + 10, -1, 60);
        chk("ab_ntrig", n_trig, 1);
        chk("ab_done_cyc", done_cyc - t0, 11);
        chk("ab_aborted", done_abt, 1);

        // count = 0
        set_cfg(1, 4, 0);
        req = 4'b0010;
        t0  = cyc;
        run_burst(-1, -1, 20);
        chk("c0_done_cyc", done_cyc - t0, 1);
        chk("c0_ntrig", n_trig, 0);

        // period = 0, count = 4
        set_cfg(3, 0, 4);
        req = 4'b1000;
        t0  = cyc;
        run_burst(-1, -1, 20);
        chk("p0_first_trig", first_trig - t0, 2);
        chk("p0_ntrig", n_trig, 4);
        chk("p0_done_cyc", done_cyc - t0, 5);

        // config change and req drop during RUN
        set_cfg(3, 4, 3);
        req = 4'b1000;
        t0  = cyc;
        run_burst(-1, t0 + 3, 60);
        chk("cs_first_trig", first_trig - t0, 5);
        chk("cs_ntrig", n_trig, 3);
        chk("cs_done_cyc", done_cyc - t0, 13);

        // asynchronous reset mid-burst
        set_cfg(0, 5, 3);
        req = 4'b0001;
        repeat (4) step();
        chk("mr_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_gnt", gnt, 0);
        chk("mr_done", done, 0);
        chk("mr_aborted", aborted, 0);
        chk("mr_trigger", trigger, 0);
        chk("mr_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        req = 4'b1001;
        step();
        chk("mr_first_grant", gnt, 4'b0001);
        req = '0;
        run_burst(-1, -1, 40);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            step();
            req = req & ~done;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_cfg(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0)
                set_cfg(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 5)),
                        int'($urandom_range(0, 3)));
            abort = ($urandom_range(0, 11) == 0);
        end
        abort = 1'b0;
        req   = '0;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_scheduler.md
# trigger_scheduler

- Shares one periodic trigger generator between `NREQ` requesters.
- Each requester asks for a burst of `count` trigger pulses spaced `period` cycles apart.
- A round-robin arbiter grants the generator to one requester at a time and latches that requester's configuration.
- A small FSM sequences load, run, completion and abort.
- Sits between the requesting control blocks and the downstream logic that consumes `trigger`.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `PW`, 8: period field width.
- `CW`, 4: burst-count field width.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester level request; held until the matching `done` pulse.
- `period`  in  NREQ*PW  packed periods; slot i = bits [PW*i+PW-1 : PW*i].
- `count`  in  NREQ*CW  packed burst lengths; slot i = bits [CW*i+CW-1 : CW*i].
- `abort`  in  1  terminates the running burst.
- `gnt`  out  NREQ  one-hot grant; all zero when idle.
- `done`  out  NREQ  one-cycle pulse on bit i when requester i's burst ends.
- `aborted`  out  1  high with `done` when the burst ended by abort.
- `trigger`  out  1  registered trigger pulse.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, RUN and DONE. All outputs and state are registered.
- **IDLE:**
  - If any `req` bit is set, select the winner round-robin: search upward from pointer `ptr`, modulo NREQ.
  - Latch `p_q = max(period[i], 1)` and `k_q = count[i]`; clear `cnt` to 0; set `gnt` to onehot(i).
  - Next state is RUN if `k_q != 0`, otherwise DONE.
- **RUN:**
  - `finished = (cnt == p_q-1)`.
  - If `abort`: clear `cnt`, set `aborted` for the DONE cycle, go to DONE, no trigger. Abort has priority over `finished` in the same cycle.
  - Else if `finished`: `cnt <= 0`, `k_q <= k_q-1`, `trigger <= 1`. If `k_q == 1`, go to DONE.
  - Else: `cnt <= cnt+1`, `trigger <= 0`.
- **DONE (exactly one cycle):**
  - `done[i] = 1`; `gnt` still asserted; `aborted` valid.
  - Next state IDLE; `ptr <= (i+1) mod NREQ`; `gnt`, `busy` and `aborted` clear.
- Configuration inputs are sampled only at grant; changes during RUN/DONE are ignored.
- Dropping `req[i]` during its own burst is ignored; the burst completes.
- `abort` in IDLE or DONE is ignored.
- `period` values 0 and 1 both give a trigger every cycle.
- `cnt` is PW bits wide; `k_q` is CW bits wide. No wrap occurs because `cnt` resets at `p_q-1`.

## Timing
- Reset values: `gnt=0`, `done=0`, `aborted=0`, `trigger=0`, `busy=0`, state IDLE, `ptr=0`, `cnt=0`, `k_q=0`. Reset takes effect immediately, including mid-burst; no `done` pulse is generated.
- Request accepted at cycle t gives first RUN cycle t+1. The first trigger is at t+1+p_q; each following trigger comes p_q cycles later.
- The last trigger and `done` pulse are in the same cycle (the DONE cycle). IDLE follows in the next cycle.
- A still-asserted `req` is re-arbitrated in that IDLE cycle. Minimum gap between bursts is one IDLE cycle.
- With `count=0`: DONE at t+1, `done` pulse at t+1, no trigger.
- Abort seen in RUN at cycle a: DONE at a+1 with `done=1`, `aborted=1`, `trigger=0`.

## Test plan
- **Single burst:** reset, then `req=0001` at cycle 0 with `period[0]=3`, `count[0]=2`.
  - Required: `gnt=0001` cycles 1–7; `trigger` high at cycles 4 and 7; `done=0001` at 7; `busy=0` at 8.
- **Round-robin:** `req=1111` held, all slots `period=1`, `count=1`.
  - Required: grants in order 0, 1, 2, 3, 0; each burst is 2 cycles (RUN, DONE), followed by 1 IDLE cycle.
- **Abort:** `period=5`, `count=3`, `abort` pulsed in the RUN cycle where `cnt=4` on the 2nd period.
  - Required: exactly one trigger seen; next cycle `done=1`, `aborted=1`, `trigger=0`.
- **Edge config:**
  - `count=0` gives a `done` pulse one cycle after grant and no trigger.
  - `period=0`, `count=4` gives 4 triggers on 4 consecutive cycles.
- **Reset mid-burst:** assert `rst` asynchronously during RUN.
  - Required: all outputs 0 before the next clock edge; after release, `req=1000` and `req=0001` together grant requester 0 first (`ptr=0`).
- **Config stability:** change `period[i]` and drop `req[i]` during RUN.
  - Required: trigger spacing stays at the latched value; `done` still pulses.
